// File: rtl/uart_frame_parser_if.sv
// Byte-in / command-out bundle between the UART receiver, the frame parser and the register logic.
// The parser takes the slave side; the byte source and command consumer take the master side.
interface uart_frame_parser_if;
    logic [7:0]  rx_data;
    logic        rx_vld;
    logic [7:0]  cmd_code;
    logic [31:0] cmd_value;
    logic        cmd_vld;
    logic        err_vld;
    logic [2:0]  err_code;
    logic        frame_busy;

    modport master (
        output rx_data, rx_vld,
        input  cmd_code, cmd_value, cmd_vld, err_vld, err_code, frame_busy
    );

    modport slave (
        input  rx_data, rx_vld,
        output cmd_code, cmd_value, cmd_vld, err_vld, err_code, frame_busy
    );
endinterface

// File: rtl/uart_frame_parser.sv
// Decodes "&&K=ddd&&" ASCII command frames from the UART byte stream into code/value pairs.
// Optional: define UART_FRAME_PARSER_HEX_EN to accept "x"-prefixed hexadecimal values.
module uart_frame_parser #(
    parameter int MAX_DIGITS  = 9,
    parameter int TIMEOUT_CLK = 5_000_000
) (
    input logic              sys_clk,
    input logic              sys_rst,
    uart_frame_parser_if.slave bus
);
    localparam int             TW        = (TIMEOUT_CLK > 2) ? $clog2(TIMEOUT_CLK) : 1;
    localparam logic [TW-1:0]  TMO_LAST  = TW'(TIMEOUT_CLK - 1);
    localparam logic [3:0]     DIGIT_MAX = 4'(MAX_DIGITS);

    localparam logic [2:0] ERR_BAD_CMD  = 3'd1;
    localparam logic [2:0] ERR_BAD_EQ   = 3'd2;
    localparam logic [2:0] ERR_BAD_CHAR = 3'd3;
    localparam logic [2:0] ERR_OVF      = 3'd4;
    localparam logic [2:0] ERR_EMPTY    = 3'd5;
    localparam logic [2:0] ERR_BAD_END  = 3'd6;
    localparam logic [2:0] ERR_TIMEOUT  = 3'd7;

    typedef enum logic [2:0] {S_IDLE, S_SIGN2, S_CMD, S_EQ, S_VALUE, S_END2} state_t;

    state_t         state_reg, state_next;
    logic [7:0]     letter_reg, letter_next;
    logic [31:0]    acc_reg, acc_next;
    logic [3:0]     digit_cnt_reg, digit_cnt_next;
    logic [TW-1:0]  tmo_cnt_reg, tmo_cnt_next;
    logic [7:0]     cmd_code_reg, cmd_code_next;
    logic [31:0]    cmd_value_reg, cmd_value_next;
    logic           cmd_vld_reg, cmd_vld_next;
    logic           err_vld_reg, err_vld_next;
    logic [2:0]     err_code_reg, err_code_next;
    logic           frame_busy_reg, frame_busy_next;
`ifdef UART_FRAME_PARSER_HEX_EN
    logic           hex_reg, hex_next;
    logic           is_hex;
    logic [3:0]     hex_nib;
`endif

    logic [7:0]     rx_byte;
    logic           is_dec;
    logic [31:0]    acc_x10;
    logic           err_hit;

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_reg      <= S_IDLE;
            letter_reg     <= '0;
            acc_reg        <= '0;
            digit_cnt_reg  <= '0;
            tmo_cnt_reg    <= '0;
            cmd_code_reg   <= '0;
            cmd_value_reg  <= '0;
            cmd_vld_reg    <= 1'b0;
            err_vld_reg    <= 1'b0;
            err_code_reg   <= '0;
            frame_busy_reg <= 1'b0;
`ifdef UART_FRAME_PARSER_HEX_EN
            hex_reg        <= 1'b0;
`endif
        end else begin
            state_reg      <= state_next;
            letter_reg     <= letter_next;
            acc_reg        <= acc_next;
            digit_cnt_reg  <= digit_cnt_next;
            tmo_cnt_reg    <= tmo_cnt_next;
            cmd_code_reg   <= cmd_code_next;
            cmd_value_reg  <= cmd_value_next;
            cmd_vld_reg    <= cmd_vld_next;
            err_vld_reg    <= err_vld_next;
            err_code_reg   <= err_code_next;
            frame_busy_reg <= frame_busy_next;
`ifdef UART_FRAME_PARSER_HEX_EN
            hex_reg        <= hex_next;
`endif
        end
    end

    always_comb begin
        rx_byte        = bus.rx_data;
        is_dec         = (rx_byte >= "0") && (rx_byte <= "9");
        acc_x10        = {acc_reg[28:0], 3'b000} + {acc_reg[30:0], 1'b0};
        state_next     = state_reg;
        letter_next    = letter_reg;
        acc_next       = acc_reg;
        digit_cnt_next = digit_cnt_reg;
        cmd_code_next  = cmd_code_reg;
        cmd_value_next = cmd_value_reg;
        cmd_vld_next   = 1'b0;
        err_vld_next   = 1'b0;
        err_code_next  = err_code_reg;
        err_hit        = 1'b0;
        tmo_cnt_next   = (bus.rx_vld || state_reg == S_IDLE) ? '0 : tmo_cnt_reg + 1'b1;
`ifdef UART_FRAME_PARSER_HEX_EN
        hex_next       = hex_reg;
        is_hex         = is_dec || (rx_byte >= "A" && rx_byte <= "F") || (rx_byte >= "a" && rx_byte <= "f");
        hex_nib        = is_dec ? rx_byte[3:0] : rx_byte[3:0] + 4'd9;
`endif

        if (bus.rx_vld) begin
            case (state_reg)
                S_IDLE:  if (rx_byte == "&") state_next = S_SIGN2;
                S_SIGN2: state_next = (rx_byte == "&") ? S_CMD : S_IDLE;
                S_CMD: begin
                    if (rx_byte >= "A" && rx_byte <= "Z") begin
                        letter_next    = rx_byte;
                        acc_next       = '0;
                        digit_cnt_next = '0;
`ifdef UART_FRAME_PARSER_HEX_EN
                        hex_next       = 1'b0;
`endif
                        state_next     = S_EQ;
                    end else begin
                        err_hit = 1'b1; err_code_next = ERR_BAD_CMD;
                    end
                end
                S_EQ: begin
                    if (rx_byte == "=") state_next = S_VALUE;
                    else begin
                        err_hit = 1'b1; err_code_next = ERR_BAD_EQ;
                    end
                end
                S_VALUE: begin
                    if (rx_byte == "&") begin
                        if (digit_cnt_reg != 4'd0) state_next = S_END2;
                        else begin
                            err_hit = 1'b1; err_code_next = ERR_EMPTY;
                        end
                    end
`ifdef UART_FRAME_PARSER_HEX_EN
                    else if (!hex_reg && digit_cnt_reg == 4'd0 && rx_byte == "x") hex_next = 1'b1;
                    else if (hex_reg) begin
                        if (!is_hex) begin
                            err_hit = 1'b1; err_code_next = ERR_BAD_CHAR;
                        end else if (digit_cnt_reg == 4'd8) begin
                            err_hit = 1'b1; err_code_next = ERR_OVF;
                        end else begin
                            acc_next       = {acc_reg[27:0], hex_nib};
                            digit_cnt_next = digit_cnt_reg + 4'd1;
                        end
                    end
`endif
                    else if (is_dec) begin
                        if (digit_cnt_reg == DIGIT_MAX) begin
                            err_hit = 1'b1; err_code_next = ERR_OVF;
                        end else begin
                            acc_next       = acc_x10 + {28'd0, rx_byte[3:0]};
                            digit_cnt_next = digit_cnt_reg + 4'd1;
                        end
                    end else begin
                        err_hit = 1'b1; err_code_next = ERR_BAD_CHAR;
                    end
                end
                S_END2: begin
                    if (rx_byte == "&") begin
                        cmd_code_next  = letter_reg;
                        cmd_value_next = acc_reg;
                        cmd_vld_next   = 1'b1;
                        state_next     = S_IDLE;
                    end else begin
                        err_hit = 1'b1; err_code_next = ERR_BAD_END;
                    end
                end
                default: state_next = S_IDLE;
            endcase
        end else if (state_reg != S_IDLE && tmo_cnt_reg == TMO_LAST) begin
            // A byte arriving on the terminal cycle takes the branch above instead.
            err_hit = 1'b1; err_code_next = ERR_TIMEOUT;
        end

        if (err_hit) begin
            err_vld_next = 1'b1;
            state_next   = S_IDLE;
        end
        frame_busy_next = (state_next != S_IDLE);
    end

    assign bus.cmd_code   = cmd_code_reg;
    assign bus.cmd_value  = cmd_value_reg;
    assign bus.cmd_vld    = cmd_vld_reg;
    assign bus.err_vld    = err_vld_reg;
    assign bus.err_code   = err_code_reg;
    assign bus.frame_busy = frame_busy_reg;
endmodule

// File: tb/tb_uart_frame_parser.sv
// Directed bench for uart_frame_parser: good frames, each abort reason, timeout, hex option, reset.
module tb_uart_frame_parser;
    localparam int TMO = 100;

    logic sys_clk = 1'b0;
    logic sys_rst = 1'b1;
    always #5 sys_clk = ~sys_clk;

    uart_frame_parser_if bus_if ();

    uart_frame_parser #(.MAX_DIGITS(9), .TIMEOUT_CLK(TMO)) dut (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .bus     (bus_if)
    );

    int total = 0;
    int bad   = 0;
    int cmd_cnt = 0, err_cnt = 0, both_cnt = 0;
    logic [7:0]  cmd_codes [8];
    logic [31:0] cmd_vals  [8];
    logic [2:0]  err_codes [8];

    always @(negedge sys_clk) begin
        if (bus_if.cmd_vld) begin
            if (cmd_cnt < 8) begin
                cmd_codes[cmd_cnt] = bus_if.cmd_code;
                cmd_vals[cmd_cnt]  = bus_if.cmd_value;
            end
            cmd_cnt++;
            $display("cmd  code=%h value=%0d", bus_if.cmd_code, bus_if.cmd_value);
        end
        if (bus_if.err_vld) begin
            if (err_cnt < 8) err_codes[err_cnt] = bus_if.err_code;
            err_cnt++;
            $display("err  code=%0d", bus_if.err_code);
        end
        if (bus_if.cmd_vld && bus_if.err_vld) both_cnt++;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout required test end");
        $fatal(1, "watchdog");
    end

    task automatic idle(input int n);
        repeat (n) begin @(posedge sys_clk); #1; end
    endtask

    task automatic send_byte(input logic [7:0] b);
        bus_if.rx_data = b;
        bus_if.rx_vld  = 1'b1;
        @(posedge sys_clk); #1;
        bus_if.rx_vld  = 1'b0;
    endtask

    task automatic send_str(input string s, input int gap);
        for (int i = 0; i < s.len(); i++) begin
            send_byte(s[i]);
            idle(gap);
        end
    endtask

    task automatic clear_counts();
        cmd_cnt = 0; err_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            cmd_codes[i] = 'x; cmd_vals[i] = 'x; err_codes[i] = 'x;
        end
    endtask

    task automatic test_reset();
        bus_if.rx_vld = 1'b0; bus_if.rx_data = 8'h00;
        sys_rst = 1'b1;
        idle(3);
        total++; if (bus_if.cmd_code !== 8'h00)   begin bad++; $display("FAIL rst_cmd_code: got %h want 00", bus_if.cmd_code); end
        total++; if (bus_if.cmd_value !== 32'd0)  begin bad++; $display("FAIL rst_cmd_value: got %0d want 0", bus_if.cmd_value); end
        total++; if (bus_if.cmd_vld !== 1'b0)     begin bad++; $display("FAIL rst_cmd_vld: got %b want 0", bus_if.cmd_vld); end
        total++; if (bus_if.err_vld !== 1'b0)     begin bad++; $display("FAIL rst_err_vld: got %b want 0", bus_if.err_vld); end
        total++; if (bus_if.err_code !== 3'd0)    begin bad++; $display("FAIL rst_err_code: got %0d want 0", bus_if.err_code); end
        total++; if (bus_if.frame_busy !== 1'b0)  begin bad++; $display("FAIL rst_busy: got %b want 0", bus_if.frame_busy); end
        sys_rst = 1'b0;
        idle(2);
    endtask

    task automatic test_single_frame();
        clear_counts();
        send_str("&&F=1000&", 3);
        total++; if (bus_if.frame_busy !== 1'b1) begin bad++; $display("FAIL single_busy: got %b want 1", bus_if.frame_busy); end
        send_byte("&");
        total++; if (bus_if.cmd_vld !== 1'b1) begin bad++; $display("FAIL single_latency: got %b want 1", bus_if.cmd_vld); end
        idle(3);
        total++; if (cmd_cnt !== 1)            begin bad++; $display("FAIL single_cnt: got %0d want 1", cmd_cnt); end
        total++; if (cmd_codes[0] !== 8'h46)   begin bad++; $display("FAIL single_code: got %h want 46", cmd_codes[0]); end
        total++; if (cmd_vals[0] !== 32'd1000) begin bad++; $display("FAIL single_value: got %0d want 1000", cmd_vals[0]); end
        total++; if (err_cnt !== 0)            begin bad++; $display("FAIL single_err: got %0d want 0", err_cnt); end
        total++; if (bus_if.frame_busy !== 1'b0) begin bad++; $display("FAIL single_idle: got %b want 0", bus_if.frame_busy); end
    endtask

    task automatic test_back_to_back();
        clear_counts();
        send_str("&&A=999999999&&&&B=0&&", 0);
        idle(3);
        total++; if (cmd_cnt !== 2)                 begin bad++; $display("FAIL b2b_cnt: got %0d want 2", cmd_cnt); end
        total++; if (cmd_codes[0] !== 8'h41)        begin bad++; $display("FAIL b2b_code0: got %h want 41", cmd_codes[0]); end
        total++; if (cmd_vals[0] !== 32'd999999999) begin bad++; $display("FAIL b2b_value0: got %0d want 999999999", cmd_vals[0]); end
        total++; if (cmd_codes[1] !== 8'h42)        begin bad++; $display("FAIL b2b_code1: got %h want 42", cmd_codes[1]); end
        total++; if (cmd_vals[1] !== 32'd0)         begin bad++; $display("FAIL b2b_value1: got %0d want 0", cmd_vals[1]); end
        total++; if (err_cnt !== 0)                 begin bad++; $display("FAIL b2b_err: got %0d want 0", err_cnt); end
    endtask

    task automatic test_overflow();
        clear_counts();
        send_str("&&A=1234567890&&", 0);
        idle(2);
        total++; if (err_cnt !== 1)               begin bad++; $display("FAIL ovf_err_cnt: got %0d want 1", err_cnt); end
        total++; if (err_codes[0] !== 3'd4)       begin bad++; $display("FAIL ovf_code: got %0d want 4", err_codes[0]); end
        total++; if (cmd_cnt !== 0)               begin bad++; $display("FAIL ovf_cmd: got %0d want 0", cmd_cnt); end
        total++; if (bus_if.cmd_code !== 8'h42)   begin bad++; $display("FAIL ovf_hold_code: got %h want 42", bus_if.cmd_code); end
        total++; if (bus_if.cmd_value !== 32'd0)  begin bad++; $display("FAIL ovf_hold_value: got %0d want 0", bus_if.cmd_value); end
        // the trailing "&&" opens a new frame that must time out
        idle(TMO + 5);
        total++; if (err_cnt !== 2)               begin bad++; $display("FAIL ovf_tail_cnt: got %0d want 2", err_cnt); end
        total++; if (err_codes[1] !== 3'd7)       begin bad++; $display("FAIL ovf_tail_code: got %0d want 7", err_codes[1]); end
    endtask

    task automatic test_errors();
        string      vec [4] = '{"&&a=5&&", "&&C5&&", "&&C=&&", "&&C=12&x"};
        logic [2:0] exp [4] = '{3'd1, 3'd2, 3'd5, 3'd6};
        for (int i = 0; i < 4; i++) begin
            clear_counts();
            send_str(vec[i], 0);
            idle(2);
            total++; if (err_codes[0] !== exp[i]) begin bad++; $display("FAIL err_%s: got %0d want %0d", vec[i], err_codes[0], exp[i]); end
            total++; if (cmd_cnt !== 0)           begin bad++; $display("FAIL err_cmd_%s: got %0d want 0", vec[i], cmd_cnt); end
            idle(TMO + 5);
            total++; if (bus_if.frame_busy !== 1'b0) begin bad++; $display("FAIL err_idle_%s: got %b want 0", vec[i], bus_if.frame_busy); end
        end
    endtask

    task automatic test_timeout();
        clear_counts();
        send_str("&&C=12", 0);
        idle(TMO - 5);
        total++; if (err_cnt !== 0)              begin bad++; $display("FAIL tmo_early: got %0d want 0", err_cnt); end
        total++; if (bus_if.frame_busy !== 1'b1) begin bad++; $display("FAIL tmo_busy: got %b want 1", bus_if.frame_busy); end
        idle(10);
        total++; if (err_cnt !== 1)              begin bad++; $display("FAIL tmo_cnt: got %0d want 1", err_cnt); end
        total++; if (err_codes[0] !== 3'd7)      begin bad++; $display("FAIL tmo_code: got %0d want 7", err_codes[0]); end
        total++; if (bus_if.frame_busy !== 1'b0) begin bad++; $display("FAIL tmo_idle: got %b want 0", bus_if.frame_busy); end
        send_str("&&D=3&&", 0);
        idle(2);
        total++; if (cmd_cnt !== 1 || cmd_codes[0] !== 8'h44 || cmd_vals[0] !== 32'd3) begin
            bad++; $display("FAIL tmo_next: got cnt=%0d %h/%0d want 1 44/3", cmd_cnt, cmd_codes[0], cmd_vals[0]);
        end
        total++; if (err_cnt !== 1)              begin bad++; $display("FAIL tmo_once: got %0d want 1", err_cnt); end
    endtask

    task automatic test_hex();
        clear_counts();
        send_str("&&H=xFF00&&", 0);
        idle(2);
`ifdef UART_FRAME_PARSER_HEX_EN
        total++; if (cmd_cnt !== 1)              begin bad++; $display("FAIL hex_cnt: got %0d want 1", cmd_cnt); end
        total++; if (cmd_vals[0] !== 32'h0000FF00) begin bad++; $display("FAIL hex_value: got %h want 0000ff00", cmd_vals[0]); end
        total++; if (err_cnt !== 0)              begin bad++; $display("FAIL hex_err: got %0d want 0", err_cnt); end
`else
        total++; if (err_codes[0] !== 3'd3)      begin bad++; $display("FAIL hex_bad_char: got %0d want 3", err_codes[0]); end
        total++; if (cmd_cnt !== 0)              begin bad++; $display("FAIL hex_cmd: got %0d want 0", cmd_cnt); end
        idle(TMO + 5);
`endif
    endtask

    task automatic test_reset_mid_frame();
        send_str("&&C=12", 0);
        total++; if (bus_if.frame_busy !== 1'b1) begin bad++; $display("FAIL mid_busy: got %b want 1", bus_if.frame_busy); end
        sys_rst = 1'b1;
        #2;
        total++; if (bus_if.cmd_code !== 8'h00)  begin bad++; $display("FAIL mid_cmd_code: got %h want 00", bus_if.cmd_code); end
        total++; if (bus_if.cmd_value !== 32'd0) begin bad++; $display("FAIL mid_cmd_value: got %0d want 0", bus_if.cmd_value); end
        total++; if (bus_if.err_code !== 3'd0)   begin bad++; $display("FAIL mid_err_code: got %0d want 0", bus_if.err_code); end
        total++; if (bus_if.frame_busy !== 1'b0) begin bad++; $display("FAIL mid_busy_clr: got %b want 0", bus_if.frame_busy); end
        @(posedge sys_clk); #1;
        sys_rst = 1'b0;
        idle(1);
        clear_counts();
        send_str("&&E=7&&", 0);
        idle(TMO + 5);
        total++; if (cmd_cnt !== 1 || cmd_codes[0] !== 8'h45 || cmd_vals[0] !== 32'd7) begin
            bad++; $display("FAIL mid_next: got cnt=%0d %h/%0d want 1 45/7", cmd_cnt, cmd_codes[0], cmd_vals[0]);
        end
        total++; if (err_cnt !== 0) begin bad++; $display("FAIL mid_no_err: got %0d want 0", err_cnt); end
    endtask

    task automatic test_exclusive();
        total++; if (both_cnt !== 0) begin bad++; $display("FAIL exclusive: got %0d overlaps want 0", both_cnt); end
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_overflow();
        test_errors();
        test_timeout();
        test_hex();
        test_reset_mid_frame();
        test_exclusive();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
